// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// A frame result is a 5-bit value: a key index 0..15, or KEY_NONE.
package key_scan_pkg;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int CODE_W   = 4;
    localparam int NKEYS    = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} scan_state_e;

    typedef logic [CODE_W:0] key_res_t;
    localparam key_res_t KEY_NONE = 5'h10;

    // Exactly one bit set gives that key; zero or several keys give KEY_NONE.
    function automatic key_res_t frame_result(input logic [NKEYS-1:0] f);
        key_res_t r;
        int       n;
        r = KEY_NONE;
        n = 0;
        for (int i = 0; i < NKEYS; i++) begin
            if (f[i]) begin
                n++;
                r = key_res_t'(i);
            end
        end
        return (n == 1) ? r : KEY_NONE;
    endfunction
endpackage

// File: rtl/key_matrix_scan_if.sv
// Keypad pins plus the key event handshake toward the consumer.
interface key_matrix_scan_if;
    logic [key_scan_pkg::KEY_COLS-1:0] key_col;
    logic [key_scan_pkg::KEY_ROWS-1:0] key_row;
    logic [key_scan_pkg::CODE_W-1:0]   key_code;
    logic                              key_valid;
    logic                              key_ready;
    logic                              key_held;
    logic                              key_ovf;

    modport master (
        input  key_col, key_ready,
        output key_row, key_code, key_valid, key_held, key_ovf
    );
    modport slave (
        output key_col, key_ready,
        input  key_row, key_code, key_valid, key_held, key_ovf
    );
endinterface

// File: rtl/key_scan_tick.sv
// Scan-step timebase: tick every TICK_DIV clocks, rotating one-cold row drive.
module key_scan_tick
    import key_scan_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tick,
    output logic [1:0]          row_index,
    output logic [KEY_ROWS-1:0] key_row
);
    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    row_next;

    assign tick     = (cnt == LAST);
    assign row_next = row_index + 2'd1;

    // key_row is registered so the pins never glitch while the index decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            row_index <= '0;
            key_row   <= 4'b1110;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                row_index <= row_next;
                key_row   <= ~(4'b0001 << row_next);
            end
        end
    end
endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: synchronizes columns, builds full-matrix frames,
// debounces whole frames and hands press events to a ready/valid consumer.
module key_matrix_scan
    import key_scan_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input logic               clk,
    input logic               rst_n,
    key_matrix_scan_if.master kbd
);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    logic [KEY_COLS-1:0] col_s1, col_s2;
    logic                tick;
    logic [1:0]          row_index;
    logic [KEY_ROWS-1:0] key_row;
    logic [NKEYS-1:0]    frame, frame_now;
    logic                frame_done;
    key_res_t            res;
    scan_state_e         state, nstate;
    logic [CODE_W-1:0]   cand, ncand, code;
    logic [3:0]          cnt, ncnt, cnt_inc;
    logic                evt, drop, valid, ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= kbd.key_col;
            col_s2 <= col_s1;
        end
    end

    key_scan_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .row_index (row_index),
        .key_row   (key_row)
    );

    // Current row's sample merged into the partial frame.
    always_comb begin
        frame_now = frame;
        for (int c = 0; c < KEY_COLS; c++) begin
            if (!col_s2[c]) frame_now[{row_index, 2'(c)}] = 1'b1;
        end
    end

    assign frame_done = tick && (row_index == 2'd3);
    assign res        = frame_result(frame_now);
    assign cnt_inc    = cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            if (tick) frame <= frame_done ? '0 : frame_now;
            state <= nstate;
            cand  <= ncand;
            cnt   <= ncnt;
        end
    end

    always_comb begin
        nstate = state;
        ncand  = cand;
        ncnt   = cnt;
        evt    = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: if (res != KEY_NONE) begin
                    ncand = res[CODE_W-1:0];
                    ncnt  = 4'd1;
                    if (DB == 4'd1) begin
                        nstate = HELD;
                        evt    = 1'b1;
                    end else begin
                        nstate = PRESS_DB;
                    end
                end
                PRESS_DB: if (res == KEY_NONE) begin
                    nstate = IDLE;
                    ncnt   = '0;
                end else if (res[CODE_W-1:0] == cand) begin
                    ncnt = cnt_inc;
                    if (cnt_inc == DB) begin
                        nstate = HELD;
                        evt    = 1'b1;
                    end
                end else begin
                    ncand = res[CODE_W-1:0];
                    ncnt  = 4'd1;
                end
                // A single NONE frame already completes release when DB is 1.
                HELD: if (res == KEY_NONE) begin
                    nstate = (DB == 4'd1) ? IDLE : REL_DB;
                    ncnt   = (DB == 4'd1) ? 4'd0 : 4'd1;
                end
                REL_DB: if (res == KEY_NONE) begin
                    ncnt = cnt_inc;
                    if (cnt_inc == DB) begin
                        nstate = IDLE;
                        ncnt   = '0;
                    end
                end else begin
                    nstate = HELD;
                    ncnt   = '0;
                end
                default: nstate = IDLE;
            endcase
        end
    end

    // A pending, unaccepted event blocks a new one; simultaneous accept frees the slot.
    assign drop = evt && valid && !kbd.key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            ovf <= drop;
            if (evt && !drop) begin
                code  <= ncand;
                valid <= 1'b1;
            end else if (valid && kbd.key_ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign kbd.key_row   = key_row;
    assign kbd.key_code  = code;
    assign kbd.key_valid = valid;
    assign kbd.key_ovf   = ovf;
    assign kbd.key_held  = (state == HELD) || (state == REL_DB);
endmodule

// File: tb/tb_key_matrix_scan.sv
// Keypad scanner bench: a frame/run-length model predicts every output each cycle;
// directed scenarios add literal expectations on codes, counts and latencies.
module tb_key_matrix_scan;
    localparam int T = 4;
    localparam int D = 3;
    localparam int W_HELD = 0, W_REL = 1, W_VALID = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;
    logic        ready = 1'b1;
    logic [3:0]  col;

    always #5 clk = ~clk;

    key_matrix_scan_if kbd();

    key_matrix_scan #(.TICK_DIV(T), .DEBOUNCE(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kbd   (kbd)
    );

    // Passive keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kbd.key_row[r] && keys[r*4+c]) col[c] = 1'b0;
    end
    assign kbd.key_col   = col;
    assign kbd.key_ready = ready;

    typedef struct {
        int          k;
        logic [15:0] frame, d1, d2;
        int          run, last, none;
        bit          held, valid, ovf;
        logic [3:0]  code;
    } mdl_t;

    mdl_t m;
    int   checks = 0, errors = 0;
    int   vcyc = 0, heldc = 0, ovfs = 0, xfers = 0;

    // One clock edge of the behavioural model; k counts edges since reset.
    function automatic mdl_t step(mdl_t s, logic [15:0] kin, logic rdy);
        int res, r;
        bit evt;
        res = -1;
        evt = 0;
        s.k++;
        if (s.k % T == 0) begin
            r = (s.k / T - 1) % 4;
            s.frame = s.frame | (s.d2 & (16'hF << (r*4)));
            if (r == 3) begin
                if ($countones(s.frame) == 1)
                    for (int i = 0; i < 16; i++) if (s.frame[i]) res = i;
                s.frame = '0;
                if (!s.held) begin
                    if (res < 0) s.run = 0;
                    else if (s.run > 0 && res == s.last) s.run++;
                    else s.run = 1;
                    s.last = res;
                    if (s.run == D) begin
                        evt = 1; s.held = 1; s.run = 0; s.none = 0;
                    end
                end else if (res < 0) begin
                    s.none++;
                    if (s.none == D) begin s.held = 0; s.none = 0; end
                end else begin
                    s.none = 0;
                end
            end
        end
        s.ovf = evt && s.valid && !rdy;
        if (evt && !s.ovf) begin
            s.code = 4'(res);
            s.valid = 1;
        end else if (!evt && s.valid && rdy) begin
            s.valid = 0;
        end
        s.d2 = s.d1;
        s.d1 = kin;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '{default: 0};
        else        m <= step(m, keys, ready);

    function automatic logic [3:0] exp_row(int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((k / T) % 4));
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic cyc();
        if (kbd.key_valid && ready) xfers++;
        @(negedge clk);
        if (rst_n) begin
            checks++;
            if ({kbd.key_row, kbd.key_code, kbd.key_valid, kbd.key_held, kbd.key_ovf} !==
                {exp_row(m.k), m.code, m.valid, m.held, m.ovf}) begin
                errors++;
                $display("FAIL model k=%0d row/code/valid/held/ovf got %b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
                         m.k, kbd.key_row, kbd.key_code, kbd.key_valid, kbd.key_held, kbd.key_ovf,
                         exp_row(m.k), m.code, m.valid, m.held, m.ovf);
            end
            if (kbd.key_valid) vcyc++;
            if (kbd.key_held)  heldc++;
            if (kbd.key_ovf)   ovfs++;
        end
    endtask

    function automatic bit cond(int sel);
        case (sel)
            W_HELD:  return kbd.key_held;
            W_REL:   return !kbd.key_held;
            default: return kbd.key_valid;
        endcase
    endfunction

    task automatic wait_for(string name, int sel, int budget, output int n);
        n = 0;
        while (!cond(sel) && n < budget) begin cyc(); n++; end
        chk(name, int'(cond(sel)), 1);
    endtask

    task automatic clr();
        vcyc = 0; heldc = 0; ovfs = 0; xfers = 0;
    endtask

    initial begin
        int n, sel;
        repeat (2) @(negedge clk);
        chk("rst_row",   int'(kbd.key_row), 4'b1110);
        chk("rst_valid", int'(kbd.key_valid), 0);
        chk("rst_held",  int'(kbd.key_held), 0);
        chk("rst_ovf",   int'(kbd.key_ovf), 0);
        chk("rst_code",  int'(kbd.key_code), 0);
        rst_n = 1'b1;

        // Key 9 (row 2, col 1), consumer always ready
        clr();
        keys = 16'h1 << 9;
        wait_for("k9_valid", W_VALID, 100, n);
        chk("k9_latency", n, 48);
        chk("k9_code", int'(kbd.key_code), 9);
        cyc();
        keys = '0;
        wait_for("k9_release", W_REL, 100, n);
        chk("k9_rel_latency", n, 47);
        chk("k9_valid_cycles", vcyc, 1);

        // Key 6 on alternate frames never debounces
        clr();
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? (16'h1 << 6) : 16'h0;
            repeat (4*T) cyc();
        end
        chk("k6_alt_valid", vcyc, 0);
        chk("k6_alt_held", heldc, 0);

        // Keys 0 and 5 together are ambiguous, then key 0 alone
        clr();
        keys = 16'h0021;
        repeat (5*4*T) cyc();
        chk("k0k5_valid", vcyc, 0);
        chk("k0k5_held", heldc, 0);
        keys = 16'h0001;
        wait_for("k0_valid", W_VALID, 100, n);
        chk("k0_code", int'(kbd.key_code), 0);
        cyc();
        keys = '0;
        wait_for("k0_release", W_REL, 100, n);

        // Stalled consumer: key 3 pending, key 7 dropped
        clr();
        ready = 1'b0;
        keys = 16'h1 << 3;
        wait_for("k3_valid", W_VALID, 100, n);
        keys = '0;
        wait_for("k3_release", W_REL, 100, n);
        clr();
        keys = 16'h1 << 7;
        wait_for("k7_held", W_HELD, 100, n);
        repeat (2) cyc();
        chk("k7_ovf_pulses", ovfs, 1);
        chk("k7_code_kept", int'(kbd.key_code), 3);
        chk("k7_valid_kept", int'(kbd.key_valid), 1);
        keys = '0;
        wait_for("k7_release", W_REL, 100, n);
        xfers = 0;
        ready = 1'b1;
        repeat (4) cyc();
        chk("k3_transfers", xfers, 1);
        chk("k3_drained", int'(kbd.key_valid), 0);

        // Accept in the same cycle as the key 12 event replaces the pending code
        ready = 1'b0;
        keys = 16'h1 << 3;
        wait_for("p3_valid", W_VALID, 100, n);
        keys = '0;
        wait_for("p3_release", W_REL, 100, n);
        clr();
        keys = 16'h1 << 12;
        n = 0;
        while (!(m.run == D-1 && m.last == 12 && !m.held && m.k % (4*T) == 4*T-1) && n < 200) begin
            cyc(); n++;
        end
        chk("k12_align", int'(n < 200), 1);
        chk("k12_pending", int'(kbd.key_valid), 1);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        chk("k12_code", int'(kbd.key_code), 12);
        chk("k12_valid", int'(kbd.key_valid), 1);
        chk("k12_no_ovf", ovfs, 0);
        keys = '0;
        ready = 1'b1;
        wait_for("k12_release", W_REL, 100, n);

        // Random key patterns and consumer backpressure
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 7);
            if (sel < 2)      keys = '0;
            else if (sel < 7) keys = 16'h1 << $urandom_range(0, 15);
            else              keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            repeat ($urandom_range(4, 70)) begin
                ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
        end

        // Reset with a key down and an event pending
        ready = 1'b0;
        keys = 16'h1 << 5;
        wait_for("pre_rst_held", W_HELD, 200, n);
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_row",   int'(kbd.key_row), 4'b1110);
        chk("mid_rst_valid", int'(kbd.key_valid), 0);
        chk("mid_rst_held",  int'(kbd.key_held), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        chk("post_rst_row0", int'(kbd.key_row), 4'b1110);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("post_rst_row0", int'(kbd.key_row), 4'b1110);
        end
        cyc();
        chk("post_rst_row1", int'(kbd.key_row), 4'b1101);
        repeat (40) cyc();
        chk("post_rst_no_event", vcyc, 0);
        wait_for("post_rst_event", W_VALID, 100, n);
        chk("post_rst_code", int'(kbd.key_code), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
